inst_fetch_queue: RTL and testbench

Requester-side fetch front end for the instruction memory: owns the fetch PC, drives the word-addressed memory's byte address every cycle and captures the combinationally returned instruction word. Fetched instructions are held in a small prefetch FIFO and handed to decode through a valid/ready handshake. A redirect from the branch/jump resolution logic flushes the queue and restarts fetch at a new PC.

---
 rtl/inst_fetch_queue_pkg.sv | 13 +
 rtl/fetch_fifo.sv | 64 ++++++
 rtl/inst_fetch_queue.sv | 72 +++++++
 tb/tb_inst_fetch_queue.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch front end.
package inst_fetch_queue_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        fault;
  } fetch_entry_t;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [31:0] PC_INC   = 32'd4;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO with async reset and a single-cycle flush.
module fetch_fifo
  import inst_fetch_queue_pkg::*;
#(
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            push_i,
  input  logic            pop_i,
  input  fetch_entry_t    wdata_i,
  output fetch_entry_t    rdata_o,
  output logic [CntW-1:0] count_o,
  output logic            full_o,
  output logic            empty_o
);

  localparam logic [PtrW-1:0] PtrOne = PtrW'(1);

  fetch_entry_t    mem_q [Depth];
  logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0] count_q, count_d;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push_i) wptr_d = wptr_q + PtrOne;
      if (pop_i)  rptr_d = rptr_q + PtrOne;
      count_d = count_q + CntW'(push_i) - CntW'(pop_i);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Data storage is intentionally left unreset.
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/inst_fetch_queue.sv
// Fetch PC, instruction memory request and prefetch queue toward decode.
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] RESET_PC  = 32'h0,
  parameter int unsigned MEM_DEPTH = 16384
) (
  input  logic        clk_i,
  input  logic        reset_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_dout_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  output logic        inst_fault_o,
  input  logic        inst_ready_i
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic            push, pop, full, empty;
  logic [CntW-1:0] count;
  fetch_entry_t    wdata, head;

  assign pop  = !empty && inst_ready_i;
  assign push = !redirect_valid_i && (!full || pop);

  assign wdata.pc    = fetch_pc_q;
  assign wdata.inst  = imem_dout_i;
  assign wdata.fault = ((fetch_pc_q >> 2) >= 32'(MEM_DEPTH));

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redirect_valid_i) fetch_pc_d = {redirect_pc_i[31:2], 2'b00};
    else if (push)        fetch_pc_d = fetch_pc_q + PC_INC;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) fetch_pc_q <= RESET_PC;
    else         fetch_pc_q <= fetch_pc_d;
  end

  fetch_fifo #(
    .Depth(DEPTH)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_i  (reset_i),
    .flush_i(redirect_valid_i),
    .push_i (push),
    .pop_i  (pop),
    .wdata_i(wdata),
    .rdata_o(head),
    .count_o(count),
    .full_o (full),
    .empty_o(empty)
  );

  count_in_range: assert property (@(posedge clk_i) disable iff (reset_i)
    count <= CntW'(DEPTH));

  assign imem_addr_o  = fetch_pc_q;
  assign inst_valid_o = !empty;
  // Empty queue shows a NOP so stale or unknown storage never reaches decode.
  assign inst_o       = empty ? NOP_INST : head.inst;
  assign inst_pc_o    = head.pc;
  assign inst_fault_o = head.fault;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench: hand-derived vector table plus a scoreboard of expected fetches.
module tb_inst_fetch_queue;
  import inst_fetch_queue_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned MEM_DEPTH = 16384;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr, imem_dout, redirect_pc, inst, inst_pc;
  logic        redirect_valid, inst_valid, inst_fault, inst_ready;

  int n_cmp = 0;
  int n_err = 0;

  fetch_entry_t q_exp[$];
  logic [31:0]  m_pc;

  typedef struct {
    logic        rdy;
    logic        rv;
    logic [31:0] rpc;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] einst;
    logic [31:0] eaddr;
  } vec_t;
  vec_t vecs[12];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h10 + (a >> 2);
  endfunction

  assign imem_dout = mem_word(imem_addr);

  always #5 clk = ~clk;

  inst_fetch_queue #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC),
    .MEM_DEPTH(MEM_DEPTH)
  ) dut (
    .clk_i           (clk),
    .reset_i         (reset),
    .imem_addr_o     (imem_addr),
    .imem_dout_i     (imem_dout),
    .redirect_valid_i(redirect_valid),
    .redirect_pc_i   (redirect_pc),
    .inst_valid_o    (inst_valid),
    .inst_o          (inst),
    .inst_pc_o       (inst_pc),
    .inst_fault_o    (inst_fault),
    .inst_ready_i    (inst_ready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle, check outputs against the scoreboard, advance the model and the clock.
  task automatic step(input logic rdy, input logic rv, input logic [31:0] rpc);
    fetch_entry_t e;
    logic         pop;
    inst_ready     = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    chk("sb_valid", 32'(inst_valid), 32'(q_exp.size() != 0));
    chk("sb_addr", imem_addr, m_pc);
    if (q_exp.size() != 0 && inst_valid === 1'b1) begin
      chk("sb_pc", inst_pc, q_exp[0].pc);
      chk("sb_inst", inst, q_exp[0].inst);
      chk("sb_fault", 32'(inst_fault), 32'(q_exp[0].fault));
    end
    pop = (q_exp.size() != 0) && rdy;
    if (rv) begin
      q_exp.delete();
      m_pc = {rpc[31:2], 2'b00};
    end else begin
      if (pop) void'(q_exp.pop_front());
      if (q_exp.size() < DEPTH) begin
        e.pc    = m_pc;
        e.inst  = mem_word(m_pc);
        e.fault = ((m_pc >> 2) >= 32'(MEM_DEPTH));
        q_exp.push_back(e);
        m_pc = m_pc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    //          rdy   rv    rpc          ev    epc          einst        eaddr
    vecs[0]  = '{1'b1, 1'b0, 32'h0,       1'b0, 32'h0,       32'h0,       32'h0};
    vecs[1]  = '{1'b1, 1'b0, 32'h0,       1'b1, 32'h0,       32'h10,      32'h4};
    vecs[2]  = '{1'b1, 1'b0, 32'h0,       1'b1, 32'h4,       32'h11,      32'h8};
    vecs[3]  = '{1'b0, 1'b0, 32'h0,       1'b1, 32'h8,       32'h12,      32'hC};
    vecs[4]  = '{1'b0, 1'b0, 32'h0,       1'b1, 32'h8,       32'h12,      32'h10};
    vecs[5]  = '{1'b0, 1'b1, 32'h103,     1'b1, 32'h8,       32'h12,      32'h14};
    vecs[6]  = '{1'b1, 1'b0, 32'h0,       1'b0, 32'h0,       32'h0,       32'h100};
    vecs[7]  = '{1'b1, 1'b0, 32'h0,       1'b1, 32'h100,     32'h50,      32'h104};
    vecs[8]  = '{1'b1, 1'b1, 32'h200,     1'b1, 32'h104,     32'h51,      32'h108};
    vecs[9]  = '{1'b1, 1'b1, 32'h300,     1'b0, 32'h0,       32'h0,       32'h200};
    vecs[10] = '{1'b1, 1'b0, 32'h0,       1'b0, 32'h0,       32'h0,       32'h300};
    vecs[11] = '{1'b1, 1'b0, 32'h0,       1'b1, 32'h300,     32'hD0,      32'h304};

    reset          = 1'b1;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    m_pc           = RESET_PC;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(inst_valid), 32'h0);
    chk("rst_addr", imem_addr, RESET_PC);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      chk($sformatf("vec%0d_valid", i), 32'(inst_valid), 32'(vecs[i].ev));
      chk($sformatf("vec%0d_addr", i), imem_addr, vecs[i].eaddr);
      if (vecs[i].ev) begin
        chk($sformatf("vec%0d_pc", i), inst_pc, vecs[i].epc);
        chk($sformatf("vec%0d_inst", i), inst, vecs[i].einst);
        chk($sformatf("vec%0d_fault", i), 32'(inst_fault), 32'h0);
      end
      step(vecs[i].rdy, vecs[i].rv, vecs[i].rpc);
    end

    // Stall until full, then release and stream without gaps.
    repeat (10) step(1'b0, 1'b0, 32'h0);
    chk("stall_addr", imem_addr, 32'h314);
    chk("stall_head", inst_pc, 32'h304);
    repeat (8) step(1'b1, 1'b0, 32'h0);

    // Full queue with a single-cycle pop: push and pop together.
    repeat (6) step(1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    repeat (2) step(1'b0, 1'b0, 32'h0);

    // End of memory: fault flag crosses at word MEM_DEPTH.
    step(1'b1, 1'b1, 32'hFFFC);
    step(1'b1, 1'b0, 32'h0);
    chk("flt_pc0", inst_pc, 32'hFFFC);
    chk("flt_0", 32'(inst_fault), 32'h0);
    step(1'b1, 1'b0, 32'h0);
    chk("flt_pc1", inst_pc, 32'h10000);
    chk("flt_1", 32'(inst_fault), 32'h1);

    // 32-bit PC wrap.
    step(1'b1, 1'b1, 32'hFFFF_FFFE);
    repeat (2) step(1'b1, 1'b0, 32'h0);
    chk("wrap_pc", inst_pc, 32'h0);
    repeat (2) step(1'b1, 1'b0, 32'h0);

    // Asynchronous reset between edges mid-stream.
    repeat (2) step(1'b0, 1'b0, 32'h0);
    #2;
    reset = 1'b1;
    #1;
    chk("async_valid", 32'(inst_valid), 32'h0);
    chk("async_addr", imem_addr, RESET_PC);
    q_exp.delete();
    m_pc = RESET_PC;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (6) step(1'b1, 1'b0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
